updown_bcd_display: RTL and testbench

UPDOWN_BCD_DISPLAY -- requirements
Module: updown_bcd_display

---
 rtl/updown_bcd_display.sv | 85 ++++++++
 tb/tb_updown_bcd_display.sv | 125 ++++++++++++
 2 files changed

// File: rtl/updown_bcd_display.sv
// updown_bcd_display: prescaled up/down BCD counter with load, limit flags and multiplexed 7-segment output
module updown_bcd_display #(
  parameter int DIGITS   = 4,
  parameter int DIV      = 50000000,
  parameter int SCAN_DIV = 50000,
  parameter int SATURATE = 0
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  at_max,
  output logic                  at_min,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [PW-1:0]          pre;
  logic [SW-1:0]          scan;
  logic [IW-1:0]          idx;
  logic [4*DIGITS-1:0]    inc, dec, clamp;
  logic                   carry, borrow, scan_wrap;
  logic [3:0]             cur;
  assign tick = pre == PW'(DIV - 1);
  assign scan_wrap = scan == SW'(SCAN_DIV - 1);
  assign an = ~(DIGITS'(1) << idx);
  // ripple carry/borrow across digits; wrap at the limits falls out naturally
  always_comb begin
    inc = count;
    dec = count;
    clamp = load_val;
    carry = 1'b1;
    borrow = 1'b1;
    at_max = 1'b1;
    at_min = 1'b1;
    cur = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      inc[4*i+:4] = carry ? (count[4*i+:4] == 4'd9 ? 4'd0 : count[4*i+:4] + 4'd1) : count[4*i+:4];
      dec[4*i+:4] = borrow ? (count[4*i+:4] == 4'd0 ? 4'd9 : count[4*i+:4] - 4'd1) : count[4*i+:4];
      carry = carry && count[4*i+:4] == 4'd9;
      borrow = borrow && count[4*i+:4] == 4'd0;
      clamp[4*i+:4] = load_val[4*i+:4] > 4'd9 ? 4'd9 : load_val[4*i+:4];
      at_max = at_max && count[4*i+:4] == 4'd9;
      at_min = at_min && count[4*i+:4] == 4'd0;
      cur = idx == IW'(i) ? count[4*i+:4] : cur;
    end
  end
  always_comb begin
    case (cur)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pre   <= '0;
      scan  <= '0;
      idx   <= '0;
      count <= '0;
    end else begin
      pre  <= tick ? '0 : pre + 1'b1;
      scan <= scan_wrap ? '0 : scan + 1'b1;
      if (scan_wrap) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      if (load) count <= clamp;
      else if (tick && en)
        count <= up_down ? ((SATURATE != 0 && at_max) ? count : inc)
                         : ((SATURATE != 0 && at_min) ? count : dec);
    end
  end
endmodule

// File: tb/tb_updown_bcd_display.sv
// tb_updown_bcd_display: directed vector bench for the BCD counter in wrap and saturate builds
module tb_updown_bcd_display;
  logic       clk_in = 1'b0;
  logic       rst = 1'b1, en = 1'b0, up_down = 1'b0, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] count0, count1;
  logic       tick0, tick1, at_max0, at_max1, at_min0, at_min1;
  logic [6:0] seg0, seg1;
  logic [1:0] an0, an1;
  int total = 0, bad = 0, cyc = 0, n;
  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       en;
    logic       ud;
    logic       on_tick;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;
  vec_t tv[23];
  updown_bcd_display #(.DIGITS(2), .DIV(4), .SCAN_DIV(2), .SATURATE(0)) dut0 (
    .clk_in(clk_in), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .count(count0), .tick(tick0), .at_max(at_max0), .at_min(at_min0), .seg(seg0), .an(an0));
  updown_bcd_display #(.DIGITS(2), .DIV(4), .SCAN_DIV(2), .SATURATE(1)) dut1 (
    .clk_in(clk_in), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .count(count1), .tick(tick1), .at_max(at_max1), .at_min(at_min1), .seg(seg1), .an(an1));
  always #5 clk_in = ~clk_in;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // cyc counts edges since the last reset edge: prescaler = cyc%4, digit index = (cyc/2)%2
  task automatic step();
    @(posedge clk_in);
    cyc = rst ? 0 : cyc + 1;
    #1;
    chk("tick0", tick0, cyc % 4 == 3);
    chk("tick1", tick1, cyc % 4 == 3);
    chk("an0", an0, ((cyc / 2) % 2) != 0 ? 2'b01 : 2'b10);
    chk("an1", an1, ((cyc / 2) % 2) != 0 ? 2'b01 : 2'b10);
  endtask
  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  initial begin
    for (int i = 0; i < 10; i++) tv[i] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, bcd(i + 1), bcd(i + 1)};
    tv[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h10, 8'h10};
    tv[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h09, 8'h09};
    tv[12] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tv[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h99, 8'h00};
    tv[14] = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 8'h99, 8'h99};
    tv[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h99};
    tv[16] = '{1'b1, 8'hAF, 1'b1, 1'b1, 1'b1, 8'h99, 8'h99};
    tv[17] = '{1'b1, 8'h5C, 1'b1, 1'b1, 1'b1, 8'h59, 8'h59};
    tv[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h60, 8'h60};
    tv[19] = '{1'b1, 8'h3A, 1'b0, 1'b0, 1'b0, 8'h39, 8'h39};
    tv[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h38, 8'h38};
    tv[21] = '{1'b1, 8'h19, 1'b0, 1'b1, 1'b0, 8'h19, 8'h19};
    tv[22] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h20, 8'h20};
    step();
    chk("rst_count0", count0, 8'h00);
    chk("rst_count1", count1, 8'h00);
    chk("rst_seg0", seg0, 7'h3F);
    chk("rst_at_min0", at_min0, 1'b1);
    chk("rst_at_max0", at_max0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 23; i++) begin
      load = tv[i].ld;
      load_val = tv[i].lv;
      en = tv[i].en;
      up_down = tv[i].on_tick ? ~tv[i].ud : tv[i].ud;
      if (tv[i].on_tick) begin
        n = 0;
        while (tick0 !== 1'b1 && n < 8) begin
          step();
          n++;
        end
        chk($sformatf("tick_wait%0d", i), tick0, 1'b1);
        up_down = tv[i].ud;
      end
      step();
      load = 1'b0;
      chk($sformatf("count0_v%0d", i), count0, tv[i].e0);
      chk($sformatf("count1_v%0d", i), count1, tv[i].e1);
      chk($sformatf("at_max0_v%0d", i), at_max0, tv[i].e0 == 8'h99);
      chk($sformatf("at_min0_v%0d", i), at_min0, tv[i].e0 == 8'h00);
      chk($sformatf("at_max1_v%0d", i), at_max1, tv[i].e1 == 8'h99);
      chk($sformatf("at_min1_v%0d", i), at_min1, tv[i].e1 == 8'h00);
    end
    en = 1'b1;
    up_down = 1'b1;
    n = 0;
    while (tick0 !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk("tick_wait_rst", tick0, 1'b1);
    rst = 1'b1;
    load = 1'b1;
    load_val = 8'h55;
    step();
    rst = 1'b0;
    load = 1'b0;
    chk("midrst_count0", count0, 8'h00);
    chk("midrst_count1", count1, 8'h00);
    chk("midrst_seg0", seg0, 7'h3F);
    chk("midrst_at_min1", at_min1, 1'b1);
    en = 1'b0;
    load = 1'b1;
    load_val = 8'h42;
    step();
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("scan_seg0", seg0, ((cyc / 2) % 2) != 0 ? 7'h66 : 7'h5B);
      chk("scan_seg1", seg1, ((cyc / 2) % 2) != 0 ? 7'h66 : 7'h5B);
      chk("scan_count0", count0, 8'h42);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
